// File: rtl/mips_pkg.sv
// Shared front-end definitions: fetch FSM states, word width and NOP.
// Reused by ifetch and the decode stage.
package mips_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] NOP_INSN = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    function automatic logic [WORD_W-1:0] pc_plus4(
        input logic [WORD_W-1:0] pc
    );
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ifetch_outreg.sv
// Valid/ready output register of the fetch stage.
// A load always wins over a consume or a flush in the same cycle.
module ifetch_outreg
    import mips_pkg::*;
#(
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic [WORD_W-1:0] pc_i,
    input  logic [WORD_W-1:0] pc4_i,
    input  logic              misalign_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] pc4_o,
    output logic              misalign_o,
    output logic              valid_o
);

    logic [DATA_W-1:0] instr_q;
    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc4_q;
    logic              mis_q;
    logic              valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_q <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            mis_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            pc4_q   <= pc4_i;
            mis_q   <= misalign_i;
            valid_q <= 1'b1;
        end else if (flush_i || ready_i) begin
            // Payload is left untouched so a drained register stays quiet.
            valid_q <= 1'b0;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc4_o      = pc4_q;
    assign misalign_o = mis_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request, branch flush
// with in-flight response dropping, valid/ready output to decode.
module ifetch
    import mips_pkg::*;
#(
    parameter int                DATA_W = WORD_W,
    parameter logic [DATA_W-1:0] NOP    = NOP_INSN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] pc_in,
    input  logic              pc_valid,
    output logic              pc_ready,
    input  logic              flush,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic [WORD_W-1:0] instr_pc4,
    output logic              instr_misalign,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] fetch_count
);

    fetch_state_e      state_q;
    logic              req_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] cnt_q;
    logic [WORD_W-1:0] cnt_d;

    logic              out_valid;
    logic              accept;
    logic              aligned;
    logic              mis_load;
    logic              ack_load;
    logic              consume;

    logic [DATA_W-1:0] ld_instr;
    logic [WORD_W-1:0] ld_pc;

    assign pc_ready = !flush && (state_q == IDLE)
                      && (!out_valid || instr_ready);

    assign accept   = pc_valid && pc_ready;
    assign aligned  = (pc_in[1:0] == 2'b00);
    assign mis_load = accept && !aligned;
    assign ack_load = (state_q == WAIT) && imem_ack && !flush;
    assign consume  = out_valid && instr_ready && !flush;

    assign ld_instr = mis_load ? NOP : imem_rdata;
    assign ld_pc    = mis_load ? pc_in : addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept && aligned) begin
                        addr_q  <= pc_in;
                        req_q   <= 1'b1;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    // An ack in the flush cycle retires the request;
                    // its data never reaches the output register.
                    if (imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end else if (flush) begin
                        state_q <= DROP;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        req_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    req_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (consume) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    ifetch_outreg #(
        .DATA_W (DATA_W)
    ) u_outreg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (mis_load || ack_load),
        .flush_i    (flush),
        .ready_i    (instr_ready),
        .instr_i    (ld_instr),
        .pc_i       (ld_pc),
        .pc4_i      (pc_plus4(ld_pc)),
        .misalign_i (mis_load),
        .instr_o    (instr),
        .pc_o       (instr_pc),
        .pc4_o      (instr_pc4),
        .misalign_o (instr_misalign),
        .valid_o    (out_valid)
    );

    assign instr_valid = out_valid;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign fetch_count = cnt_q;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: fetch latency, stalls, flush, misalign, reset.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc4;
    logic        instr_misalign;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] fetch_count;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    exp_t ob;
    exp_t ex;
    int   total;
    int   passed;

    ifetch dut (
        .clk            (clk),
        .reset          (reset),
        .pc_in          (pc_in),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_pc4      (instr_pc4),
        .instr_misalign (instr_misalign),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memrd(input logic [31:0] a);
        return {a[15:0], 16'hBEEF} ^ 32'h1357_0000;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        pc_in = '0;
        pc_valid = 1'b0;
        flush = 1'b0;
        imem_ack = 1'b0;
        imem_rdata = '0;
        instr_ready = 1'b0;
        tick();
        tick();
        total++;
        if ({imem_req, imem_addr} !== 33'd0)
            $display("FAIL rst_req: got %b/%h want 0/0", imem_req, imem_addr);
        else passed++;
        total++;
        ob = {instr, instr_pc, instr_pc4, instr_misalign};
        if (ob !== '0) $display("FAIL rst_out: got %h want 0", ob);
        else passed++;
        total++;
        if (instr_valid !== 1'b0)
            $display("FAIL rst_valid: got %b want 0", instr_valid);
        else passed++;
        total++;
        if (fetch_count !== 32'd0)
            $display("FAIL rst_cnt: got %0d want 0", fetch_count);
        else passed++;
        total++;
        if (pc_ready !== 1'b1)
            $display("FAIL rst_ready: got %b want 1", pc_ready);
        else passed++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_zero_wait;
        logic [31:0] a;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'(i * 4);
            pc_in = a;
            pc_valid = 1'b1;
            #1;
            total++;
            if (pc_ready !== 1'b1)
                $display("FAIL zw_ready%0d: got %b want 1", i, pc_ready);
            else passed++;
            sb.push_back('{ins: memrd(a), pc: a, pc4: a + 32'd4, mis: 1'b0});
            tick();
            pc_valid = 1'b0;
            total++;
            if ({imem_req, imem_addr} !== {1'b1, a})
                $display("FAIL zw_req%0d: got %b/%h want 1/%h",
                         i, imem_req, imem_addr, a);
            else passed++;
            imem_ack = 1'b1;
            imem_rdata = memrd(a);
            tick();
            imem_ack = 1'b0;
            total++;
            if (instr_valid !== 1'b1)
                $display("FAIL zw_valid%0d: got %b want 1", i, instr_valid);
            else passed++;
            ob = {instr, instr_pc, instr_pc4, instr_misalign};
            ex = (sb.size() != 0) ? sb.pop_front() : 'x;
            total++;
            if (ob !== ex)
                $display("FAIL zw_data%0d: got %h want %h", i, ob, ex);
            else passed++;
        end
        tick();
        total++;
        if ({instr_valid, fetch_count} !== {1'b0, 32'd3})
            $display("FAIL zw_cnt: got %b/%0d want 0/3",
                     instr_valid, fetch_count);
        else passed++;
    endtask

    task automatic test_wait_delay;
        pc_in = 32'h100;
        pc_valid = 1'b1;
        sb.push_back('{ins: memrd(32'h100), pc: 32'h100,
                       pc4: 32'h104, mis: 1'b0});
        tick();
        pc_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if ({imem_req, imem_addr, pc_ready} !== {1'b1, 32'h100, 1'b0})
                $display("FAIL dly_hold%0d: got %b/%h/%b want 1/100/0",
                         k, imem_req, imem_addr, pc_ready);
            else passed++;
            total++;
            if (instr_valid !== 1'b0)
                $display("FAIL dly_early%0d: got %b want 0", k, instr_valid);
            else passed++;
            if (k == 2) begin
                imem_ack = 1'b1;
                imem_rdata = memrd(32'h100);
            end
            tick();
        end
        imem_ack = 1'b0;
        ob = {instr, instr_pc, instr_pc4, instr_misalign};
        ex = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++;
        if ({instr_valid, ob} !== {1'b1, ex})
            $display("FAIL dly_data: got %b/%h want 1/%h", instr_valid, ob, ex);
        else passed++;
        tick();
        total++;
        if (fetch_count !== 32'd4)
            $display("FAIL dly_cnt: got %0d want 4", fetch_count);
        else passed++;
    endtask

    task automatic test_backpressure;
        instr_ready = 1'b0;
        pc_in = 32'h300;
        pc_valid = 1'b1;
        sb.push_back('{ins: memrd(32'h300), pc: 32'h300,
                       pc4: 32'h304, mis: 1'b0});
        tick();
        pc_valid = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = memrd(32'h300);
        tick();
        imem_ack = 1'b0;
        pc_in = 32'h304;
        pc_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if ({pc_ready, imem_req, instr_valid, instr_pc, instr} !==
                {1'b0, 1'b0, 1'b1, 32'h300, memrd(32'h300)})
                $display("FAIL bp_hold%0d: rdy=%b req=%b v=%b pc=%h i=%h",
                         k, pc_ready, imem_req, instr_valid, instr_pc, instr);
            else passed++;
            tick();
        end
        instr_ready = 1'b1;
        #1;
        total++;
        if (pc_ready !== 1'b1)
            $display("FAIL bp_release: got %b want 1", pc_ready);
        else passed++;
        ob = {instr, instr_pc, instr_pc4, instr_misalign};
        ex = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++;
        if (ob !== ex) $display("FAIL bp_data: got %h want %h", ob, ex);
        else passed++;
        sb.push_back('{ins: memrd(32'h304), pc: 32'h304,
                       pc4: 32'h308, mis: 1'b0});
        tick();
        pc_valid = 1'b0;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h304})
            $display("FAIL bp_next: got %b/%h want 1/304", imem_req, imem_addr);
        else passed++;
        imem_ack = 1'b1;
        imem_rdata = memrd(32'h304);
        tick();
        imem_ack = 1'b0;
        ob = {instr, instr_pc, instr_pc4, instr_misalign};
        ex = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++;
        if ({instr_valid, ob} !== {1'b1, ex})
            $display("FAIL bp_data2: got %b/%h want 1/%h", instr_valid, ob, ex);
        else passed++;
        tick();
        total++;
        if (fetch_count !== 32'd6)
            $display("FAIL bp_cnt: got %0d want 6", fetch_count);
        else passed++;
    endtask

    task automatic test_flush;
        pc_in = 32'h200;
        pc_valid = 1'b1;
        tick();
        flush = 1'b1;
        pc_in = 32'h600;
        #1;
        total++;
        if (pc_ready !== 1'b0)
            $display("FAIL fl_ready: got %b want 0", pc_ready);
        else passed++;
        tick();
        flush = 1'b0;
        pc_valid = 1'b0;
        total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200})
            $display("FAIL fl_drop: got %b/%h want 1/200", imem_req, imem_addr);
        else passed++;
        tick();
        total++;
        if ({imem_req, pc_ready} !== 2'b10)
            $display("FAIL fl_hold: got %b/%b want 1/0", imem_req, pc_ready);
        else passed++;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        total++;
        if ({instr_valid, imem_req, fetch_count} !== {2'b00, 32'd6})
            $display("FAIL fl_discard: v=%b req=%b cnt=%0d want 0/0/6",
                     instr_valid, imem_req, fetch_count);
        else passed++;
        pc_in = 32'h400;
        pc_valid = 1'b1;
        sb.push_back('{ins: memrd(32'h400), pc: 32'h400,
                       pc4: 32'h404, mis: 1'b0});
        tick();
        pc_valid = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = memrd(32'h400);
        tick();
        imem_ack = 1'b0;
        ob = {instr, instr_pc, instr_pc4, instr_misalign};
        ex = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++;
        if ({instr_valid, ob} !== {1'b1, ex})
            $display("FAIL fl_next: got %b/%h want 1/%h", instr_valid, ob, ex);
        else passed++;
        tick();
        total++;
        if (fetch_count !== 32'd7)
            $display("FAIL fl_cnt: got %0d want 7", fetch_count);
        else passed++;
    endtask

    task automatic test_misalign;
        instr_ready = 1'b0;
        pc_in = 32'h202;
        pc_valid = 1'b1;
        sb.push_back('{ins: 32'h0, pc: 32'h202, pc4: 32'h206, mis: 1'b1});
        tick();
        pc_valid = 1'b0;
        total++;
        if (imem_req !== 1'b0)
            $display("FAIL mis_req: got %b want 0", imem_req);
        else passed++;
        ob = {instr, instr_pc, instr_pc4, instr_misalign};
        ex = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++;
        if ({instr_valid, ob} !== {1'b1, ex})
            $display("FAIL mis_data: got %b/%h want 1/%h", instr_valid, ob, ex);
        else passed++;
        instr_ready = 1'b1;
        pc_in = 32'hFFFF_FFFE;
        pc_valid = 1'b1;
        sb.push_back('{ins: 32'h0, pc: 32'hFFFF_FFFE,
                       pc4: 32'h0000_0002, mis: 1'b1});
        #1;
        total++;
        if (pc_ready !== 1'b1)
            $display("FAIL mis_ready: got %b want 1", pc_ready);
        else passed++;
        tick();
        pc_valid = 1'b0;
        instr_ready = 1'b0;
        ob = {instr, instr_pc, instr_pc4, instr_misalign};
        ex = (sb.size() != 0) ? sb.pop_front() : 'x;
        total++;
        if ({instr_valid, imem_req, ob} !== {2'b10, ex})
            $display("FAIL mis_wrap: got %b/%b/%h want 1/0/%h",
                     instr_valid, imem_req, ob, ex);
        else passed++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if ({instr_valid, fetch_count} !== {1'b0, 32'd8})
            $display("FAIL mis_flush: got %b/%0d want 0/8",
                     instr_valid, fetch_count);
        else passed++;
    endtask

    task automatic test_reset_mid_wait;
        instr_ready = 1'b1;
        pc_in = 32'h500;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        total++;
        if (imem_req !== 1'b1)
            $display("FAIL rmw_req: got %b want 1", imem_req);
        else passed++;
        reset = 1'b1;
        #1;
        total++;
        if ({imem_req, instr_valid} !== 2'b00)
            $display("FAIL rmw_async: got %b/%b want 0/0",
                     imem_req, instr_valid);
        else passed++;
        tick();
        reset = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = memrd(32'h500);
        tick();
        imem_ack = 1'b0;
        total++;
        if ({instr_valid, imem_req, fetch_count} !== {2'b00, 32'd0})
            $display("FAIL rmw_late: v=%b req=%b cnt=%0d want 0/0/0",
                     instr_valid, imem_req, fetch_count);
        else passed++;
        tick();
        total++;
        if ({instr_valid, sb.size() == 0} !== 2'b01)
            $display("FAIL rmw_idle: v=%b sb=%0d want 0/0",
                     instr_valid, sb.size());
        else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        test_reset();
        test_zero_wait();
        test_wait_delay();
        test_backpressure();
        test_flush();
        test_misalign();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction-fetch stage, directly downstream of the program counter.
- Takes one fetch address per handshake from the PC stage and issues a single-outstanding request to instruction memory, which may have variable latency.
- Presents the returned instruction, its PC and PC+4 to decode through a valid/ready output register.
- Supports branch flush, including discarding a response that is still in flight.

Parameters:
- DATA_W, 32, instruction width.
- NOP, 32'h00000000, instruction emitted with a misalign fault.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pc_in  in  32  fetch address from the PC stage.
- pc_valid  in  1  pc_in is valid.
- pc_ready  out  1  ifetch accepts pc_in this cycle.
- flush  in  1  branch/redirect; kill in-flight and buffered fetches.
- imem_req  out  1  memory request.
- imem_addr  out  32  memory address.
- imem_ack  in  1  memory response valid.
- imem_rdata  in  DATA_W  memory response data.
- instr  out  DATA_W  fetched instruction.
- instr_pc  out  32  address of instr.
- instr_pc4  out  32  instr_pc + 4, modulo 2^32.
- instr_misalign  out  1  pc_in[1:0] was nonzero.
- instr_valid  out  1  output register holds an instruction.
- instr_ready  in  1  decode consumes the output this cycle.
- fetch_count  out  32  count of instructions delivered.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; imem_req=0; imem_addr=0; instr=0; instr_pc=0; instr_pc4=0; instr_misalign=0; instr_valid=0; fetch_count=0. All other logic is synchronous to posedge clk.
- States: IDLE, WAIT (request outstanding), DROP (request outstanding, response to be discarded).
- pc_ready = !flush & state==IDLE & (!instr_valid | instr_ready). This is combinational and independent of pc_valid.
- Accept = pc_valid & pc_ready.
  - Aligned address: imem_addr<=pc_in, imem_req<=1, state->WAIT.
  - Misaligned address (pc_in[1:0]!=0): no memory request. The output register loads instr=NOP, instr_pc=pc_in, instr_pc4=pc_in+4, instr_misalign=1, instr_valid=1. State stays IDLE.
- WAIT:
  - imem_req and imem_addr are held stable until imem_ack.
  - On imem_ack without flush: instr<=imem_rdata, instr_pc<=imem_addr, instr_pc4<=imem_addr+4, instr_misalign<=0, instr_valid<=1, imem_req<=0, state->IDLE.
  - Only one request is ever outstanding, so the output register is always empty in WAIT.
- DROP: imem_req stays high until imem_ack. On ack, discard data, imem_req<=0, state->IDLE.
- Flush (highest priority):
  - instr_valid<=0 next cycle.
  - pc_valid is ignored that cycle.
  - WAIT with no ack -> DROP.
  - WAIT with ack in the same cycle -> data discarded, IDLE.
  - DROP or IDLE: state unchanged apart from the DROP ack handling above.
- Output handshake:
  - instr_valid & instr_ready & !flush clears instr_valid, unless a misaligned accept reloads the register in the same cycle.
  - Outputs are held stable while instr_valid & !instr_ready.
- fetch_count increments on every instr_valid & instr_ready & !flush and wraps at 2^32.
- imem_ack in IDLE is ignored. This includes a late ack after a reset that happened mid-WAIT.
- Latency: accept in cycle N; imem_req high in N+1; ack in cycle M>=N+1; instr_valid in M+1. With a zero-wait memory (ack in N+1), instr_valid is in N+2.
- Peak throughput: one instruction per 2 cycles.

Decomposition:
- Shared package mips_pkg: state enum {IDLE, WAIT, DROP}, NOP constant, and the 32-bit word width constant, reused by decode.
- One sub-module is natural: ifetch_outreg, the valid/ready output register holding instr/pc/pc4/misalign.
- The FSM and the counter stay in ifetch.

Test Plan:
- Zero-wait memory: pc_in=0x0, 0x4, 0x8 with instr_ready=1 -> instr=mem[0..2] with instr_pc4=0x4, 0x8, 0xC; each instr_valid 2 cycles after accept; fetch_count=3.
- Memory with 3-cycle ack delay on pc_in=0x100 -> imem_req held high for 3 cycles with imem_addr=0x100; pc_ready=0 throughout; instr_valid one cycle after ack.
- instr_ready=0 for 4 cycles with instr_valid=1 -> instr/instr_pc stable, pc_ready=0, no new imem_req; on release, next accept proceeds.
- flush one cycle after accepting 0x200 (ack 2 cycles later) -> state DROP, ack data discarded, instr_valid stays 0, fetch_count unchanged; next pc 0x400 fetched normally.
- pc_in=0x202 -> no imem_req; instr=NOP, instr_misalign=1, instr_pc=0x202, instr_pc4=0x206.
- reset asserted mid-WAIT -> imem_req=0 immediately, instr_valid=0; a late imem_ack afterwards produces no output.
